// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode map, response
// record and the opcode legality helper.
package alu_arbiter_pkg;

    localparam int NPORTS = 2;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MAX = 4'd8;

    typedef struct packed {
        logic [31:0] s;
        logic        sign;
        logic        err;
    } rsp_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return (op > OP_MAX);
    endfunction

endpackage

// File: rtl/alu_rsp_hold.sv
// One-entry response buffer used when a port cannot take its result in the
// cycle the ALU produces it.
module alu_rsp_hold
    import alu_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_clear,
    input  rsp_t i_data,
    output logic o_valid,
    output rsp_t o_data
);

    logic r_valid;
    rsp_t r_data;

    // Entry state: load wins over clear; both never occur together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= r_data;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between two requesters, with
// per-port result buffering and illegal-opcode screening.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [1:0][31:0]  i_req_a,
    input  logic [1:0][31:0]  i_req_b,
    input  logic [1:0][4:0]   i_req_bitNum,
    input  logic [1:0][3:0]   i_req_aluOP,
    input  logic [1:0]        i_req_isSigned,
    output logic [1:0]        o_rsp_valid,
    input  logic [1:0]        i_rsp_ready,
    output logic [1:0][31:0]  o_rsp_s,
    output logic [1:0]        o_rsp_sign,
    output logic [1:0]        o_rsp_err,
    output logic [31:0]       o_alu_a,
    output logic [31:0]       o_alu_b,
    output logic [4:0]        o_alu_bitNum,
    output logic [3:0]        o_alu_aluOP,
    output logic              o_alu_isSigned,
    input  logic [31:0]       i_alu_s,
    input  logic              i_alu_sign
);

    logic r_inflight_valid;
    logic r_inflight_id;
    logic r_inflight_signed;
    logic r_inflight_err;
    logic r_rr_last;

    logic [1:0] w_illegal;
    logic [1:0] w_inf_here;
    logic [1:0] w_elig;
    logic [1:0] w_gnt;
    logic [1:0] w_hold_valid;
    logic [1:0] w_hold_load;
    logic [1:0] w_hold_clear;
    logic       w_gnt_id;
    logic       w_gnt_any;
    logic       w_gnt_legal;
    rsp_t       w_inf_rsp;
    rsp_t       w_hold_data [NPORTS];

    genvar p;
    generate
        for (p = 0; p < NPORTS; p++) begin : g_port
            assign w_illegal[p]  = op_illegal(i_req_aluOP[p]);
            assign w_inf_here[p] = r_inflight_valid & (r_inflight_id == 1'(p));
            // A legal request may not change ALU signedness under a legal op in flight.
            assign w_elig[p] = i_req_valid[p] & ~w_hold_valid[p]
                             & ~(w_inf_here[p] & ~i_rsp_ready[p])
                             & ~(r_inflight_valid & ~r_inflight_err & ~w_illegal[p]
                                 & (i_req_isSigned[p] != r_inflight_signed));
            assign w_hold_load[p]  = w_inf_here[p] & ~i_rsp_ready[p];
            assign w_hold_clear[p] = w_hold_valid[p] & i_rsp_ready[p];

            alu_rsp_hold u_hold (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_load  (w_hold_load[p]),
                .i_clear (w_hold_clear[p]),
                .i_data  (w_inf_rsp),
                .o_valid (w_hold_valid[p]),
                .o_data  (w_hold_data[p])
            );
        end
    endgenerate

    // Round-robin pick: on contention the port that did not win last time.
    always_comb begin
        w_gnt = 2'b00;
        if (i_rst) begin
            w_gnt = 2'b00;
        end else if (w_elig == 2'b11) begin
            w_gnt = r_rr_last ? 2'b01 : 2'b10;
        end else begin
            w_gnt = w_elig;
        end
    end

    assign w_gnt_id    = w_gnt[1];
    assign w_gnt_any   = |w_gnt;
    assign w_gnt_legal = w_gnt_any & ~w_illegal[w_gnt_id];
    assign o_req_ready = w_gnt;

    // ALU operand drive; illegal grants leave the ALU at idle values.
    always_comb begin
        o_alu_a        = 32'd0;
        o_alu_b        = 32'd0;
        o_alu_bitNum   = 5'd0;
        o_alu_aluOP    = OP_AND;
        o_alu_isSigned = 1'b0;
        if (w_gnt_legal) begin
            o_alu_a      = i_req_a[w_gnt_id];
            o_alu_b      = i_req_b[w_gnt_id];
            o_alu_bitNum = i_req_bitNum[w_gnt_id];
            o_alu_aluOP  = i_req_aluOP[w_gnt_id];
        end else begin
            o_alu_aluOP  = OP_AND;
        end
        // alu_sign is combinational on isSigned, so the in-flight op owns it.
        if (r_inflight_valid & ~r_inflight_err) begin
            o_alu_isSigned = r_inflight_signed;
        end else if (w_gnt_any) begin
            o_alu_isSigned = i_req_isSigned[w_gnt_id];
        end else begin
            o_alu_isSigned = 1'b0;
        end
    end

    // Result of the in-flight op as seen by its port this cycle.
    always_comb begin
        w_inf_rsp = '0;
        if (r_inflight_err) begin
            w_inf_rsp.s    = 32'd0;
            w_inf_rsp.sign = 1'b0;
            w_inf_rsp.err  = 1'b1;
        end else begin
            w_inf_rsp.s    = i_alu_s;
            w_inf_rsp.sign = i_alu_sign;
            w_inf_rsp.err  = 1'b0;
        end
    end

    // Per-port response mux: a buffered result takes precedence.
    always_comb begin
        o_rsp_valid = 2'b00;
        o_rsp_s     = '0;
        o_rsp_sign  = 2'b00;
        o_rsp_err   = 2'b00;
        for (int i = 0; i < NPORTS; i++) begin
            if (i_rst) begin
                o_rsp_valid[i] = 1'b0;
            end else if (w_hold_valid[i]) begin
                o_rsp_valid[i] = 1'b1;
                o_rsp_s[i]     = w_hold_data[i].s;
                o_rsp_sign[i]  = w_hold_data[i].sign;
                o_rsp_err[i]   = w_hold_data[i].err;
            end else if (w_inf_here[i]) begin
                o_rsp_valid[i] = 1'b1;
                o_rsp_s[i]     = w_inf_rsp.s;
                o_rsp_sign[i]  = w_inf_rsp.sign;
                o_rsp_err[i]   = w_inf_rsp.err;
            end else begin
                o_rsp_valid[i] = 1'b0;
            end
        end
    end

    // In-flight tracking and round-robin history.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight_valid  <= 1'b0;
            r_inflight_id     <= 1'b0;
            r_inflight_signed <= 1'b0;
            r_inflight_err    <= 1'b0;
            r_rr_last         <= 1'b1;
        end else if (w_gnt_any) begin
            r_inflight_valid  <= 1'b1;
            r_inflight_id     <= w_gnt_id;
            r_inflight_signed <= i_req_isSigned[w_gnt_id];
            r_inflight_err    <= w_illegal[w_gnt_id];
            r_rr_last         <= w_gnt_id;
        end else begin
            r_inflight_valid  <= 1'b0;
            r_inflight_id     <= r_inflight_id;
            r_inflight_signed <= r_inflight_signed;
            r_inflight_err    <= r_inflight_err;
            r_rr_last         <= r_rr_last;
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU between two requesters (port 0: execute stage, port 1: address/branch helper) with round-robin arbitration. Each port has a valid/ready request handshake and a valid/ready response handshake. The block tracks the one in-flight ALU operation and its signedness. It buffers one unaccepted result per port and screens out opcodes the ALU does not define.

## Interface
- NPORTS, 2, number of requesters (fixed; the RTL supports 2 only)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  [1:0]  request valid per port
- req_ready  out  [1:0]  request accepted (grant) this cycle
- req_a, req_b  in  2x32 each  operands per port
- req_bitNum  in  2x5  shift amount per port
- req_aluOP  in  2x4  opcode per port
- req_isSigned  in  [1:0]  signed-mode flag per port
- rsp_valid  out  [1:0]  response valid per port
- rsp_ready  in  [1:0]  response accepted per port
- rsp_s  out  2x32  result per port
- rsp_sign  out  [1:0]  sign/overflow-corrected sign per port
- rsp_err  out  [1:0]  opcode was illegal (>8)
- alu_a, alu_b  out  32 each  to ALU
- alu_bitNum  out  5  to ALU
- alu_aluOP  out  4  to ALU
- alu_isSigned  out  1  to ALU
- alu_s  in  32  from ALU
- alu_sign  in  1  from ALU

## Operation
- ALU contract:
  - The ALU registers its result at the edge ending the issue cycle N.
  - alu_s is valid throughout cycle N+1.
  - alu_sign is combinational on alu_isSigned, so alu_isSigned in N+1 must equal the in-flight op's flag.
- State:
  - inflight_valid, inflight_id, inflight_signed, inflight_err
  - rr_last: last granted port; reset 1, so port 0 wins first
  - per port: hold_valid, hold_s, hold_sign, hold_err
- Eligibility of port i in cycle N requires all of:
  - req_valid[i] and !hold_valid[i]
  - not (inflight_valid and inflight_id==i and !rsp_ready[i])
  - not (inflight_valid and !inflight_err and req_isSigned[i] != inflight_signed) — signedness hazard
  - Illegal opcodes skip the signedness check.
- Grant:
  - At most one grant per cycle.
  - If both ports are eligible, grant the port != rr_last.
  - If only one is eligible, grant it. A blocked preferred port does not stall the other.
  - req_ready[i] = grant[i]. rr_last updates only on a grant.
- ALU drive in cycle N:
  - On a legal grant: the granted port's operands, opcode, bitNum and isSigned.
  - Otherwise: a=b=0, bitNum=0, aluOP=0.
  - alu_isSigned = inflight_signed if inflight_valid and !inflight_err; else the granted flag; else 0.
- Illegal opcode (9..15):
  - Accepted but never issued (ALU inputs are the idle values).
  - Marked inflight_err. The response is s=0, sign=0, err=1.
- Response for port i in cycle N:
  - If hold_valid[i]: rsp = hold contents.
  - Else if inflight_valid and inflight_id==i: rsp = alu_s/alu_sign, or the zero/err response for an illegal op.
  - rsp_valid[i] is asserted in either case.
  - If inflight targets i and !rsp_ready[i]: capture into hold at the end of N.
  - Hold clears when rsp_ready[i] is high while hold_valid[i] is set.
  - A hold and an in-flight op never coexist for the same port (guaranteed by the eligibility rule).
- Per-port ordering is strict FIFO, one result per accepted request.

## Timing
- Grant to rsp_valid latency: 1 cycle when unblocked. Throughput: 1 op/cycle across both ports.
- A back-to-back same-port issue is allowed when that port's rsp_ready is high in the response cycle.
- Reset values (synchronous, at the next clk edge):
  - inflight_valid=0, hold_valid=0, rr_last=1
  - all req_ready and rsp_valid = 0
  - ALU drive = idle values; rsp_s=0, rsp_sign=0, rsp_err=0
- Reset mid-operation drops in-flight and held results with no response.
- req_ready may depend combinationally on rsp_ready and on request inputs; rsp_valid does not depend on req_valid.

## Structure
- Shared package holds:
  - ALU opcode constants: AND=0, OR=1, SUB=2, ADD=3, XOR=4, NOR=5, SLL=6, SRL=7, SRA=8
  - OP_MAX=8
  - a response struct {s, sign, err}
- One sub-module, alu_rsp_hold: a 1-entry response register (load/clear/valid), instantiated per port.

## Test plan
- Port 0 only, ADD a=5, b=7, unsigned → req_ready[0] in cycle 0; rsp_valid[0] in cycle 1 with s=12, sign=0.
- Both ports valid every cycle, rsp_ready=11 → grants alternate 0,1,0,1 starting with port 0; one response per cycle, each on the correct port.
- Port 0 SUB a=0x7FFFFFFF, b=0xFFFFFFFF signed, then port 1 unsigned ADD the next cycle → port 1 is stalled one cycle by the signedness hazard; port 0 gets s=0x80000000, sign=0.
- Port 1 rsp_ready=0 for 3 cycles after a grant → result held and rsp_valid[1] stays high; port 1 is not granted again; port 0 traffic continues; on release the held value is delivered once.
- Port 0 opcode 12 → accepted and not issued; next cycle s=0, sign=0, err=1.
- rst asserted the cycle after a grant → no rsp_valid afterwards; first post-reset grant goes to port 0.
